// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arb_pkg;

  localparam int unsigned CntWidth = 8;

  typedef logic [CntWidth-1:0] cnt_t;
  typedef logic                mid_t;
  typedef logic [1:0]          state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StBusy = 2'd1;
  localparam state_t StResp = 2'd2;

endpackage

// File: rtl/bus_arbiter_if.sv
// Master-side request/response signals plus the single downstream bus.
interface bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  logic                  i_m0_req;
  logic                  i_m1_req;
  logic [ADDR_WIDTH-1:0] i_m0_addr;
  logic [ADDR_WIDTH-1:0] i_m1_addr;
  logic [DATA_WIDTH-1:0] i_m0_wdata;
  logic [DATA_WIDTH-1:0] i_m1_wdata;
  logic                  i_m0_we;
  logic                  i_m1_we;
  logic [BeWidth-1:0]    i_m0_be;
  logic [BeWidth-1:0]    i_m1_be;
  logic                  o_m0_ack;
  logic                  o_m1_ack;
  logic                  o_m0_err;
  logic                  o_m1_err;
  logic [DATA_WIDTH-1:0] o_m0_rdata;
  logic [DATA_WIDTH-1:0] o_m1_rdata;

  logic                  o_bus_req;
  logic [ADDR_WIDTH-1:0] o_bus_addr;
  logic [DATA_WIDTH-1:0] o_bus_wdata;
  logic                  o_bus_we;
  logic [BeWidth-1:0]    o_bus_be;
  logic [DATA_WIDTH-1:0] i_bus_rdata;
  logic                  i_bus_ack;

  // Arbiter's view.
  modport slave (
    input  i_m0_req, i_m1_req, i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata,
    input  i_m0_we, i_m1_we, i_m0_be, i_m1_be, i_bus_rdata, i_bus_ack,
    output o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_m0_rdata, o_m1_rdata,
    output o_bus_req, o_bus_addr, o_bus_wdata, o_bus_we, o_bus_be
  );

  // Environment's view: masters plus interconnect.
  modport master (
    output i_m0_req, i_m1_req, i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata,
    output i_m0_we, i_m1_we, i_m0_be, i_m1_be, i_bus_rdata, i_bus_ack,
    input  o_m0_ack, o_m1_ack, o_m0_err, o_m1_err, o_m0_rdata, o_m1_rdata,
    input  o_bus_req, o_bus_addr, o_bus_wdata, o_bus_we, o_bus_be
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin pick; the last-grant pointer advances only on a grant strobe.
module arb_rr2
  import bus_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [1:0] req_i,
  input  logic       grant_i,
  output mid_t       winner_o
);

  mid_t last_q, last_d;

  always_comb begin
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      default: winner_o = ~last_q;
    endcase
  end

  assign last_d = grant_i ? winner_o : last_q;

  // Pointer resets to "m1 served last" so m0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master to one-bus arbiter: round-robin grant, latched bus fields,
// owner-routed response and a no-ack timeout.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic          i_clk,
  input logic          i_reset_n,
  bus_arbiter_if.slave bus
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam cnt_t        CntLast = cnt_t'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  mid_t                  owner_q, owner_d;
  mid_t                  winner;
  cnt_t                  cnt_q, cnt_d;
  logic                  bus_req_q, bus_req_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic [BeWidth-1:0]    be_q, be_d;
  logic [1:0]            ack_q, ack_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q [2];
  logic [DATA_WIDTH-1:0] rdata_d [2];
  logic                  grant;

  assign grant = (state_q == StIdle) && (bus.i_m0_req || bus.i_m1_req);

  arb_rr2 u_arb (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .req_i     ({bus.i_m1_req, bus.i_m0_req}),
    .grant_i   (grant),
    .winner_o  (winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    bus_req_d = bus_req_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    ack_d     = '0;
    err_d     = '0;
    case (state_q)
      StIdle: begin
        if (grant) begin
          owner_d   = winner;
          addr_d    = winner ? bus.i_m1_addr  : bus.i_m0_addr;
          wdata_d   = winner ? bus.i_m1_wdata : bus.i_m0_wdata;
          we_d      = winner ? bus.i_m1_we    : bus.i_m0_we;
          be_d      = winner ? bus.i_m1_be    : bus.i_m0_be;
          bus_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = StBusy;
        end
      end
      StBusy: begin
        // A real ack takes priority over a timeout landing on the same cycle.
        if (bus.i_bus_ack) begin
          rdata_d[owner_q] = bus.i_bus_rdata;
          ack_d[owner_q]   = 1'b1;
          bus_req_d        = 1'b0;
          state_d          = StResp;
        end else if (cnt_q == CntLast) begin
          rdata_d[owner_q] = '0;
          ack_d[owner_q]   = 1'b1;
          err_d[owner_q]   = 1'b1;
          bus_req_d        = 1'b0;
          state_d          = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Acked master's req is still high here, so no grant is considered.
      StResp: state_d = StIdle;
      default: begin
        state_d   = StIdle;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      bus_req_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      ack_q     <= '0;
      err_q     <= '0;
      rdata_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      bus_req_q <= bus_req_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      be_q      <= be_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.o_bus_req   = bus_req_q;
  assign bus.o_bus_addr  = addr_q;
  assign bus.o_bus_wdata = wdata_q;
  assign bus.o_bus_we    = we_q;
  assign bus.o_bus_be    = be_q;
  assign bus.o_m0_ack    = ack_q[0];
  assign bus.o_m1_ack    = ack_q[1];
  assign bus.o_m0_err    = err_q[0];
  assign bus.o_m1_err    = err_q[1];
  assign bus.o_m0_rdata  = rdata_q[0];
  assign bus.o_m1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench: directed scenarios then randomized traffic against a
// transaction-level model of grant order, latency, timeout and response routing.
module tb_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  bus_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bif.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: pending requests, their fields, last read data per master.
  bit            m_req   [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  bit            m_we    [2];
  logic [BW-1:0] m_be    [2];
  logic [DW-1:0] m_rdata [2];
  int            last_served;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int m, input bit req, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input bit we, input logic [BW-1:0] be);
    m_req[m] = req; m_addr[m] = a; m_wdata[m] = d; m_we[m] = we; m_be[m] = be;
    if (m == 0) begin
      bif.i_m0_req = req; bif.i_m0_addr = a; bif.i_m0_wdata = d;
      bif.i_m0_we = we; bif.i_m0_be = be;
    end else begin
      bif.i_m1_req = req; bif.i_m1_addr = a; bif.i_m1_wdata = d;
      bif.i_m1_we = we; bif.i_m1_be = be;
    end
  endtask

  task automatic new_req(input int m);
    set_req(m, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), BW'($urandom));
  endtask

  function automatic int pick();
    if (m_req[0] && !m_req[1]) return 0;
    if (m_req[1] && !m_req[0]) return 1;
    return 1 - last_served;
  endfunction

  // Starts at a negedge with the DUT idle and requests applied; ends at the
  // negedge of the idle cycle following the response.
  task automatic run_txn(input int ack_dly, input logic [DW-1:0] rd);
    int w;
    bit done;
    bit timed;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    bit ewe;
    logic [BW-1:0] ebe;
    w = pick();
    last_served = w;
    ea = m_addr[w]; ew = m_wdata[w]; ewe = m_we[w]; ebe = m_be[w];
    @(posedge clk);
    @(negedge clk);
    if (w == 0) begin bif.i_m0_wdata = $urandom; bif.i_m0_be = BW'($urandom); end
    else        begin bif.i_m1_wdata = $urandom; bif.i_m1_be = BW'($urandom); end
    done = 1'b0;
    for (int k = 0; k < int'(TO) && !done; k++) begin
      check_eq("busy_req", 64'(bif.o_bus_req), 64'(1));
      check_eq("busy_addr", 64'(bif.o_bus_addr), 64'(ea));
      check_eq("busy_wdata", 64'(bif.o_bus_wdata), 64'(ew));
      check_eq("busy_we_be", 64'({bif.o_bus_we, bif.o_bus_be}), 64'({ewe, ebe}));
      check_eq("busy_acks", 64'({bif.o_m1_ack, bif.o_m0_ack}), 64'(0));
      bif.i_bus_ack   = (k == ack_dly);
      bif.i_bus_rdata = (k == ack_dly) ? rd : DW'($urandom);
      if (k == ack_dly || k == int'(TO) - 1) done = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    timed = !(ack_dly >= 0 && ack_dly < int'(TO));
    m_rdata[w] = timed ? '0 : rd;
    check_eq("resp_req", 64'(bif.o_bus_req), 64'(0));
    check_eq("resp_ack", 64'({bif.o_m1_ack, bif.o_m0_ack}), 64'(2'b01 << w));
    check_eq("resp_err", 64'({bif.o_m1_err, bif.o_m0_err}), timed ? 64'(2'b01 << w) : 64'(0));
    check_eq("resp_rd0", 64'(bif.o_m0_rdata), 64'(m_rdata[0]));
    check_eq("resp_rd1", 64'(bif.o_m1_rdata), 64'(m_rdata[1]));
    set_req(w, 1'b0, m_addr[w], m_wdata[w], m_we[w], m_be[w]);
    bif.i_bus_ack = 1'($urandom); bif.i_bus_rdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_req", 64'(bif.o_bus_req), 64'(0));
    check_eq("idle_ack_err", 64'({bif.o_m1_ack, bif.o_m0_ack, bif.o_m1_err, bif.o_m0_err}),
             64'(0));
    check_eq("idle_rd0", 64'(bif.o_m0_rdata), 64'(m_rdata[0]));
    check_eq("idle_rd1", 64'(bif.o_m1_rdata), 64'(m_rdata[1]));
    bif.i_bus_ack = 1'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, 64'({bif.o_bus_req, bif.o_bus_we, bif.o_bus_be, bif.o_m0_ack,
                                 bif.o_m1_ack, bif.o_m0_err, bif.o_m1_err}), 64'(0));
    check_eq({tag, "_addr"}, 64'(bif.o_bus_addr), 64'(0));
    check_eq({tag, "_wdata"}, 64'(bif.o_bus_wdata), 64'(0));
    check_eq({tag, "_rdata"}, 64'({bif.o_m1_rdata, bif.o_m0_rdata}), 64'(0));
  endtask

  task automatic model_reset();
    last_served = 1;
    m_rdata[0] = '0; m_rdata[1] = '0;
    set_req(0, 1'b0, '0, '0, 1'b0, '0);
    set_req(1, 1'b0, '0, '0, 1'b0, '0);
    bif.i_bus_ack = 1'b0; bif.i_bus_rdata = '0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset");

    // Contention after reset: m0 first, then m1, then alternation on the next tie.
    set_req(0, 1'b1, 32'h0000_1000, 32'h0, 1'b0, 4'hF);
    set_req(1, 1'b1, 32'h0000_2000, 32'h0, 1'b0, 4'hF);
    run_txn(1, 32'hA5A5_0001);
    run_txn(1, 32'hA5A5_0002);
    set_req(0, 1'b1, 32'h0000_1004, 32'h0, 1'b0, 4'hF);
    set_req(1, 1'b1, 32'h0000_2004, 32'h0, 1'b0, 4'hF);
    run_txn(0, 32'hA5A5_0003);
    run_txn(2, 32'hA5A5_0004);

    // Single read, timeout write, ack on the final timeout cycle, held write fields.
    set_req(0, 1'b1, 32'h0000_1000, 32'h0, 1'b0, 4'hF);
    run_txn(1, 32'hDEAD_BEEF);
    set_req(1, 1'b1, 32'h0000_3000, 32'hCAFE_F00D, 1'b1, 4'hF);
    run_txn(-1, 32'h0);
    set_req(0, 1'b1, 32'h0000_4000, 32'h0, 1'b0, 4'hF);
    run_txn(int'(TO) - 1, 32'h1357_9BDF);
    set_req(0, 1'b1, 32'h0000_5000, 32'h1234_5678, 1'b1, 4'b0011);
    run_txn(2, 32'h0);

    // Asynchronous reset in the middle of a transaction.
    set_req(0, 1'b1, 32'h0000_6000, 32'h0, 1'b0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_busy", 64'(bif.o_bus_req), 64'(1));
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("no_ack_after_rst", 64'({bif.o_m1_ack, bif.o_m0_ack, bif.o_bus_req}), 64'(0));
    end
    set_req(1, 1'b1, 32'h0000_7000, 32'h0, 1'b0, 4'hF);
    run_txn(0, 32'h2468_ACE0);

    // Randomized traffic.
    for (int it = 0; it < 120; it++) begin
      if (!m_req[0] && !m_req[1]) begin
        int idle;
        int pat;
        idle = int'($urandom_range(0, 2));
        for (int c = 0; c < idle; c++) begin
          @(posedge clk);
          @(negedge clk);
          check_eq("rand_idle_req", 64'(bif.o_bus_req), 64'(0));
        end
        pat = int'($urandom_range(1, 3));
        if (pat[0]) new_req(0);
        if (pat[1]) new_req(1);
      end else if ($urandom_range(0, 1) == 1) begin
        if (!m_req[0]) new_req(0);
        else new_req(1);
      end
      run_txn(int'($urandom_range(0, TO + 1)) - 1, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
